// File: rtl/fp16_pkg.sv
// FP16 constants and the stage-1 bundle shared by the
// denormalize slice of the sqrt datapath.
package fp16_pkg;

  localparam logic [6:0]  BIAS    = 7'd15;
  localparam logic [4:0]  EXP_MAX = 5'd31;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] PINF    = 16'h7C00;
  localparam logic [15:0] NINF    = 16'hFC00;

  localparam int M_HID     = 12;
  localparam int M_FRAC_HI = 11;
  localparam int M_FRAC_LO = 2;
  localparam int M_GRD     = 1;
  localparam int M_STK     = 0;

  typedef enum logic [2:0] {
    K_NUM,
    K_ZERO,
    K_NAN,
    K_PINF,
    K_NINF
  } kind_t;

  typedef struct packed {
    logic        sign;
    kind_t       kind;
    logic [6:0]  exp;
    logic [12:0] mant;
  } s1_t;

endpackage

// File: rtl/denormalize_if.sv
// Operand-in / result-out bundle of the denormalize stage.
interface denormalize_if;

  logic        enable;
  logic        in_valid;
  logic        is_num;
  logic        is_nan;
  logic        is_pinf;
  logic        is_ninf;
  logic        sign_in;
  logic [6:0]  exp_in;
  logic [12:0] mant_in;
  logic        out_valid;
  logic [15:0] result;

  modport master (
    output enable, in_valid,
    output is_num, is_nan,
    output is_pinf, is_ninf,
    output sign_in, exp_in,
    output mant_in,
    input  out_valid, result
  );

  modport slave (
    input  enable, in_valid,
    input  is_num, is_nan,
    input  is_pinf, is_ninf,
    input  sign_in, exp_in,
    input  mant_in,
    output out_valid, result
  );

endinterface

// File: rtl/denormalize_prims.sv
// Structural datapath primitives: ripple adder and
// 2:1 mux, shared with the rest of the sqrt datapath.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[N];

endmodule

module mux2_n #(
  parameter int N = 8
) (
  input  logic         sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/shift_right_sticky_13bit.sv
// 13-bit log shifter; every bit shifted out is ORed
// into bit 0. Amounts of 13..15 leave only the sticky.
module shift_right_sticky_13bit (
  input  logic [12:0] din,
  input  logic [3:0]  amt,
  output logic [12:0] dout
);

  logic [12:0] d1, d2, d4, d8;
  logic        l1, l2, l4, l8;

  mux2_n #(.N(13)) u_s1 (
    .sel (amt[0]),
    .a   (din),
    .b   ({1'b0, din[12:1]}),
    .y   (d1)
  );
  assign l1 = amt[0] & din[0];

  mux2_n #(.N(13)) u_s2 (
    .sel (amt[1]),
    .a   (d1),
    .b   ({2'b0, d1[12:2]}),
    .y   (d2)
  );
  assign l2 = amt[1] & (|d1[1:0]);

  mux2_n #(.N(13)) u_s4 (
    .sel (amt[2]),
    .a   (d2),
    .b   ({4'b0, d2[12:4]}),
    .y   (d4)
  );
  assign l4 = amt[2] & (|d2[3:0]);

  mux2_n #(.N(13)) u_s8 (
    .sel (amt[3]),
    .a   (d4),
    .b   ({8'b0, d4[12:8]}),
    .y   (d8)
  );
  assign l8 = amt[3] & (|d4[7:0]);

  assign dout = {d8[12:1],
                 d8[0] | l1 | l2 | l4 | l8};

endmodule

// File: rtl/denormalize.sv
// FP16 denormalize: bias/subnormal shift in stage 1,
// RNE rounding and packing in stage 2.
module denormalize
  import fp16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  denormalize_if.slave bus
);

  logic [6:0]  e_b;
  logic [6:0]  amt;
  logic [3:0]  amt4;
  logic        e_norm;
  logic [12:0] m_sub;
  logic [12:0] m_s1;
  logic [6:0]  e_s1;
  kind_t       kind_d;
  s1_t         s1_d;
  s1_t         s1_q;
  logic        s1_v;
  logic        c_bias, c_amt, c_einc;

  adder_n #(.N(7)) u_bias (
    .a  (bus.exp_in),
    .b  (BIAS),
    .ci (1'b0),
    .s  (e_b),
    .co (c_bias)
  );

  assign e_norm = ~e_b[6] & (|e_b[5:0]);

  // 1 - e as ~e + 1 + 1
  adder_n #(.N(7)) u_amt (
    .a  (~e_b),
    .b  (7'd1),
    .ci (1'b1),
    .s  (amt),
    .co (c_amt)
  );

  mux2_n #(.N(4)) u_amt_sat (
    .sel (|amt[6:4]),
    .a   (amt[3:0]),
    .b   (4'hF),
    .y   (amt4)
  );

  shift_right_sticky_13bit u_shift (
    .din  (bus.mant_in),
    .amt  (amt4),
    .dout (m_sub)
  );

  mux2_n #(.N(13)) u_msel (
    .sel (e_norm),
    .a   (m_sub),
    .b   (bus.mant_in),
    .y   (m_s1)
  );

  mux2_n #(.N(7)) u_esel (
    .sel (e_norm),
    .a   (7'd0),
    .b   (e_b),
    .y   (e_s1)
  );

  // Flags overlap, so priority chain rather than unique
  always_comb begin
    kind_d = K_NUM;
    if (bus.is_nan)
      kind_d = K_NAN;
    else if (bus.is_pinf)
      kind_d = K_PINF;
    else if (bus.is_ninf)
      kind_d = K_NINF;
    else if (bus.is_num && bus.mant_in == '0)
      kind_d = K_ZERO;
  end

  assign s1_d = '{
    sign: bus.sign_in,
    kind: kind_d,
    exp:  e_s1,
    mant: m_s1
  };

  logic [9:0]  frac;
  logic [9:0]  frac_r;
  logic        rnd_up;
  logic [6:0]  exp_r;
  logic        ovf;
  logic [15:0] num_res;
  logic [15:0] res_d;

  assign frac   = s1_q.mant[M_FRAC_HI:M_FRAC_LO];
  assign rnd_up = s1_q.mant[M_GRD]
                & (s1_q.mant[M_STK] | frac[0]);

  adder_n #(.N(10)) u_rnd (
    .a  (frac),
    .b  (10'd0),
    .ci (rnd_up),
    .s  (frac_r),
    .co (c_einc)
  );

  logic c_exp;

  adder_n #(.N(7)) u_einc (
    .a  (s1_q.exp),
    .b  (7'd0),
    .ci (c_einc),
    .s  (exp_r),
    .co (c_exp)
  );

  assign ovf = (|exp_r[6:5])
             | (exp_r[4:0] == EXP_MAX);

  mux2_n #(.N(16)) u_ovf (
    .sel (ovf),
    .a   ({s1_q.sign, exp_r[4:0], frac_r}),
    .b   ({s1_q.sign, PINF[14:0]}),
    .y   (num_res)
  );

  always_comb begin
    res_d = num_res;
    unique case (s1_q.kind)
      K_NAN:   res_d = QNAN;
      K_PINF:  res_d = PINF;
      K_NINF:  res_d = NINF;
      K_ZERO:  res_d = {s1_q.sign, 15'h0000};
      default: res_d = num_res;
    endcase
  end

  logic        ov_q;
  logic [15:0] res_q;

  always_ff @(posedge clk) begin
    if (!rst_n || !bus.enable) begin
      s1_v  <= 1'b0;
      s1_q  <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
    end else begin
      s1_v <= bus.in_valid;
      if (bus.in_valid)
        s1_q <= s1_d;
      ov_q <= s1_v;
      if (s1_v)
        res_q <= res_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;

  logic unused_bits;
  assign unused_bits = ^{c_bias, c_amt, c_exp,
                         s1_q.mant[M_HID]};

endmodule

// File: tb/tb_denormalize.sv
// Bench for denormalize: constant vector table, random
// operands against an arithmetic model, flush/reset runs.
module tb_denormalize;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  denormalize_if bus ();

  denormalize dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          num;
    bit          nan;
    bit          pinf;
    bit          ninf;
    bit          sign;
    int          exp;
    logic [12:0] mant;
  } op_t;

  typedef struct {
    op_t         op;
    logic [15:0] want;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] val;
  } pend_t;

  pend_t       sb[$];
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] exp_res = '0;

  function automatic op_t mk(bit num, bit nan,
                             bit pinf, bit ninf,
                             bit sign, int exp,
                             logic [12:0] mant);
    op_t o;
    o.num  = num;
    o.nan  = nan;
    o.pinf = pinf;
    o.ninf = ninf;
    o.sign = sign;
    o.exp  = exp;
    o.mant = mant;
    return o;
  endfunction

  // Value-level model: integer exponent/fraction math.
  function automatic logic [15:0] ref_res(op_t o);
    int          e;
    int          sh;
    int          v;
    int          fr;
    logic [12:0] m;
    bit          up;
    if (o.nan)  return 16'h7E00;
    if (o.pinf) return 16'h7C00;
    if (o.ninf) return 16'hFC00;
    if (o.num && o.mant == 0)
      return {o.sign, 15'h0000};
    e = o.exp + 15;
    if (e >= 1) begin
      m = o.mant;
    end else begin
      sh = 1 - e;
      if (sh >= 13)
        m = {12'b0, |o.mant};
      else
        m = (o.mant >> sh)
          | 13'((o.mant & ((1 << sh) - 1)) != 0);
      e = 0;
    end
    fr = int'(m[11:2]);
    up = m[1] && (m[0] || (fr % 2 == 1));
    v  = e * 1024 + fr + (up ? 1 : 0);
    if (v >= 31 * 1024)
      return {o.sign, 15'h7C00};
    return {o.sign, v[14:0]};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  k;
    k = $urandom_range(0, 15);
    o.nan  = (k == 0);
    o.pinf = (k == 1) || (k == 0 && $urandom_range(0, 1) == 1);
    o.ninf = (k == 2) || (k < 2 && $urandom_range(0, 1) == 1);
    o.num  = (k >= 3) || ($urandom_range(0, 1) == 1);
    o.sign = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 1)
      o.exp = int'($urandom_range(0, 112)) - 64;
    else
      o.exp = int'($urandom_range(0, 50)) - 30;
    o.mant = 13'($urandom());
    if ($urandom_range(0, 3) != 0)
      o.mant[12] = 1'b1;
    if ($urandom_range(0, 9) == 0)
      o.mant = '0;
    return o;
  endfunction

  task automatic check(string name, logic [15:0] got,
                       logic [15:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               name, cyc, got, want);
    end
  endtask

  // One clock: drive, advance, update scoreboard, compare.
  task automatic step(string ph, bit r, bit en, bit v,
                      op_t o, logic [15:0] want);
    logic ev;
    rst_n        = r;
    bus.enable   = en;
    bus.in_valid = v;
    bus.is_num   = o.num;
    bus.is_nan   = o.nan;
    bus.is_pinf  = o.pinf;
    bus.is_ninf  = o.ninf;
    bus.sign_in  = o.sign;
    bus.exp_in   = 7'(o.exp);
    bus.mant_in  = o.mant;
    @(posedge clk);
    #1;
    ev = 1'b0;
    if (!r || !en) begin
      sb.delete();
      exp_res = '0;
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        ev      = 1'b1;
        exp_res = sb[0].val;
        sb.delete(0);
      end
      if (v)
        sb.push_back(pend_t'{cyc + 1, want});
    end
    check({ph, ".out_valid"},
          {15'b0, bus.out_valid}, {15'b0, ev});
    check({ph, ".result"}, bus.result, exp_res);
    cyc++;
  endtask

  vec_t tbl [18];
  op_t  idle;
  op_t  a, b, c, d, e, f, g;

  initial begin
    idle = mk(1, 0, 0, 0, 0, 0, 13'h0000);

    tbl[0]  = '{mk(1,0,0,0,0,   0,13'h1000), 16'h3C00};
    tbl[1]  = '{mk(1,0,0,0,0, -14,13'h1000), 16'h0400};
    tbl[2]  = '{mk(1,0,0,0,0, -15,13'h1000), 16'h0200};
    tbl[3]  = '{mk(1,0,0,0,0, -40,13'h1FFF), 16'h0000};
    tbl[4]  = '{mk(1,0,0,0,0,   0,13'h1006), 16'h3C02};
    tbl[5]  = '{mk(1,0,0,0,0,   0,13'h1002), 16'h3C00};
    tbl[6]  = '{mk(1,0,0,0,0,  15,13'h1FFE), 16'h7C00};
    tbl[7]  = '{mk(1,0,0,0,1,  16,13'h1000), 16'hFC00};
    tbl[8]  = '{mk(0,1,1,0,0,   3,13'h1234), 16'h7E00};
    tbl[9]  = '{mk(1,0,0,0,1,   5,13'h0000), 16'h8000};
    tbl[10] = '{mk(1,0,1,0,1,   2,13'h1111), 16'h7C00};
    tbl[11] = '{mk(1,0,0,1,0,   2,13'h1111), 16'hFC00};
    tbl[12] = '{mk(1,0,0,0,0, -15,13'h1FFF), 16'h0400};
    tbl[13] = '{mk(1,0,0,0,0,   1,13'h1200), 16'h4080};
    tbl[14] = '{mk(1,0,0,0,0,   0,13'h1003), 16'h3C01};
    tbl[15] = '{mk(1,0,0,0,0, -24,13'h1000), 16'h0001};
    tbl[16] = '{mk(1,0,0,0,0, -25,13'h1000), 16'h0000};
    tbl[17] = '{mk(1,0,0,0,0,  16,13'h0000), 16'h0000};

    for (int i = 0; i < 3; i++)
      step("reset", 0, 1, 1, tbl[0].op, tbl[0].want);

    // Isolated: exact latency per vector
    for (int i = 0; i < 18; i++) begin
      step("tbl", 1, 1, 1, tbl[i].op, tbl[i].want);
      step("tbl", 1, 1, 0, idle, '0);
      step("tbl", 1, 1, 0, idle, '0);
    end

    // Back-to-back stream of the same table
    for (int i = 0; i < 18; i++)
      step("stream", 1, 1, 1, tbl[i].op, tbl[i].want);
    step("stream", 1, 1, 0, idle, '0);
    step("stream", 1, 1, 0, idle, '0);

    // Dropped operand while disabled
    step("drop", 1, 0, 1, tbl[0].op, tbl[0].want);
    step("drop", 1, 1, 0, idle, '0);
    step("drop", 1, 1, 0, idle, '0);

    for (int i = 0; i < 600; i++) begin
      op_t o;
      bit  r, en, v;
      o  = rand_op();
      r  = ($urandom_range(0, 49) != 0);
      en = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 9) < 7);
      step("rand", r, en, v, o, ref_res(o));
    end
    step("rand", 1, 1, 0, idle, '0);
    step("rand", 1, 1, 0, idle, '0);

    a = mk(1, 0, 0, 0, 0,  2, 13'h1A5C);
    b = mk(1, 0, 0, 0, 1, -3, 13'h1333);
    c = mk(1, 0, 0, 0, 0, -18, 13'h1F0F);
    d = mk(1, 0, 0, 0, 1,  7, 13'h10F3);
    e = mk(1, 0, 0, 0, 0, -1, 13'h1801);
    f = mk(1, 0, 0, 0, 1, 10, 13'h1444);
    g = mk(1, 0, 0, 0, 0,  4, 13'h1C2A);

    // Three captures, one-cycle flush, then reset
    step("seq", 1, 1, 1, a, ref_res(a));
    step("seq", 1, 1, 1, b, ref_res(b));
    step("seq", 1, 1, 1, c, ref_res(c));
    step("seq", 1, 0, 1, d, ref_res(d));
    step("seq", 1, 1, 1, e, ref_res(e));
    step("seq", 1, 1, 0, idle, '0);
    step("seq", 1, 1, 1, f, ref_res(f));
    step("seq", 0, 1, 1, g, ref_res(g));
    step("seq", 0, 1, 0, idle, '0);
    for (int i = 0; i < 3; i++)
      step("seq", 1, 1, 0, idle, '0);
    step("seq", 1, 1, 1, g, ref_res(g));
    step("seq", 1, 1, 0, idle, '0);
    step("seq", 1, 1, 0, idle, '0);
    step("seq", 1, 1, 0, idle, '0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/denormalize.md
DENORMALIZE -- requirements
Module: denormalize

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for FP16.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 enable  input  1  stage enable; low flushes the pipeline.
REQ-005 in_valid  input  1  input operand valid, sampled when enable=1.
REQ-006 is_num  input  1  operand is a finite number (zero included).
REQ-007 is_nan  input  1  operand is NaN.
REQ-008 is_pinf  input  1  operand is +inf.
REQ-009 is_ninf  input  1  operand is -inf.
REQ-010 sign_in  input  1  sign of the finite operand.
REQ-011 exp_in  input  7  signed two's-complement unbiased exponent.
REQ-012 mant_in  input  13  [12] hidden bit, [11:2] fraction, [1] guard, [0] sticky; 0 means zero.
REQ-013 out_valid  output  1  one-cycle pulse per accepted operand.
REQ-014 result  output  16  packed IEEE-754 binary16 result.

Function
REQ-015 Accept: capture = enable AND in_valid; every capture SHALL produce exactly one out_valid pulse 2 cycles later, with back-to-back captures sustained at one per cycle.
REQ-016 Stage-1 registers SHALL load only on capture and hold otherwise; stage-2 registers SHALL load only when stage-1 valid AND enable, and hold otherwise.
REQ-017 enable=0 SHALL clear both valid bits and all data registers on the next edge (a flush, not a stall), matching the upstream normalize behaviour.
REQ-018 Special priority: is_nan > is_pinf > is_ninf > is_num; NaN -> 16'h7E00, +inf -> 16'h7C00, -inf -> 16'hFC00, with mant_in and exp_in ignored.
REQ-019 Zero: is_num with mant_in=0 -> {sign_in, 15'h0000}, so -0 is preserved.
REQ-020 Stage 1: biased exponent e = exp_in + 15, computed in 7-bit signed arithmetic; if e >= 1, the mantissa passes unshifted.
REQ-021 Stage 1 subnormal: if e <= 0, the 13-bit mantissa SHALL shift right by (1 - e); every bit shifted out SHALL OR into bit [0]; shifts >= 13 SHALL leave only the sticky bit (OR of all of mant_in); the stored exponent field is 0.
REQ-022 Stage 2 rounding SHALL be round-to-nearest-even: round up iff guard AND (sticky OR frac LSB).
REQ-023 A fraction carry-out from rounding SHALL increment the exponent field; a subnormal that rounds up to 1.0 x 2^-14 SHALL become 16'h0400.
REQ-024 Overflow: a final exponent field >= 31, before or after rounding, SHALL produce {sign_in, 15'h7C00}.
REQ-025 Result assembly: {sign, exp[4:0], frac[9:0]}.
REQ-026 in_valid with enable=0 SHALL be dropped with no pulse produced.

Reset
REQ-027 rst_n=0 at a clock edge SHALL clear out_valid, result (to 16'h0000), and all stage valid and data registers; reset overrides enable and capture.
REQ-028 Operations in flight when reset is asserted SHALL be discarded, with no out_valid for them after reset release.
REQ-029 The first capture after reset release SHALL behave as in REQ-015.

Structure
REQ-030 Shared package fp16_pkg SHALL hold BIAS=15, EXP_MAX=31, QNAN=16'h7E00, PINF=16'h7C00, NINF=16'hFC00, and the mant_in bit-position constants.
REQ-031 The right shifter with sticky collection SHALL be a separate sub-module, shift_right_sticky_13bit (13-bit in, 4-bit amount saturating at 13, 13-bit out).
REQ-032 The design SHALL use only structural adder_n, mux2_n, and register-style primitives in line with the rest of the sqrt datapath; no behavioural arithmetic operators.

Verification
REQ-033 exp_in=0, mant_in=13'h1000, is_num=1 -> result 16'h3C00 with out_valid exactly 2 cycles after capture.
REQ-034 exp_in=-14, mant_in=13'h1000 -> 16'h0400; exp_in=-15 -> 16'h0200; exp_in=-40, mant_in=13'h1FFF -> 16'h0000.
REQ-035 exp_in=0, frac LSB=1, guard=1, sticky=0 (mant_in=13'h1006) -> 16'h3C02; the same with frac LSB=0 (13'h1002) -> 16'h3C00.
REQ-036 exp_in=15, mant_in=13'h1FFE -> 16'h7C00 (rounding overflow); exp_in=16, sign_in=1 -> 16'hFC00.
REQ-037 is_nan=1 with is_pinf=1 -> 16'h7E00; is_num=1, mant_in=0, sign_in=1 -> 16'h8000.
REQ-038 Three back-to-back captures, then enable=0 for one cycle in the middle, then rst_n=0 -> the pulses that were not flushed come out in order; no out_valid for flushed operands or during or after reset.
